// File: rtl/mem_port_arbiter.sv
// Three-port arbiter for the shared single-port program/data memory.
// Round-robin (or fetch-priority) grant, command mux and read-return routing.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 26,
  parameter int MEM_LAT    = 1,
  parameter int PRIO_FETCH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]               last_q;
  logic [1:0]               last_d;
  logic [2:0]               gnt_c;
  logic [1:0]               gnt_id;
  logic [MEM_LAT-1:0]       vld_q;
  logic [MEM_LAT-1:0]       vld_d;
  logic [MEM_LAT-1:0][1:0]  id_q;
  logic [MEM_LAT-1:0][1:0]  id_d;
  logic                     tail_v;
  logic [1:0]               tail_id;
  logic                     unused_we0;

  assign unused_we0 = we[0];

  // Priority order is last+1, last+2, last (mod 3)
  always_comb begin
    gnt_c = 3'b000;
    if (PRIO_FETCH != 0) begin
      if (req[0]) begin
        gnt_c = 3'b001;
      end else if (last_q == 2'd1) begin
        if (req[2])      gnt_c = 3'b100;
        else if (req[1]) gnt_c = 3'b010;
      end else begin
        if (req[1])      gnt_c = 3'b010;
        else if (req[2]) gnt_c = 3'b100;
      end
    end else begin
      unique case (last_q)
        2'd0: begin
          if (req[1])      gnt_c = 3'b010;
          else if (req[2]) gnt_c = 3'b100;
          else if (req[0]) gnt_c = 3'b001;
        end
        2'd1: begin
          if (req[2])      gnt_c = 3'b100;
          else if (req[0]) gnt_c = 3'b001;
          else if (req[1]) gnt_c = 3'b010;
        end
        default: begin
          if (req[0])      gnt_c = 3'b001;
          else if (req[1]) gnt_c = 3'b010;
          else if (req[2]) gnt_c = 3'b100;
        end
      endcase
    end
  end

  // No grant is offered while the block is held in reset
  assign gnt    = rst_n ? gnt_c : 3'b000;
  assign mem_en = |gnt;

  always_comb begin
    gnt_id    = 2'd0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        gnt_id   = 2'd0;
        mem_addr = addr0;
      end
      gnt[1]: begin
        gnt_id    = 2'd1;
        mem_we    = we[1];
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      gnt[2]: begin
        gnt_id    = 2'd2;
        mem_we    = we[2];
        mem_addr  = addr2;
        mem_wdata = wdata2;
      end
      default: begin
        gnt_id = 2'd0;
      end
    endcase
  end

  assign last_d = mem_en ? gnt_id : last_q;

  // Return tracker mirrors the memory latency; writes ride along as bubbles
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = mem_en & ~mem_we;
    id_d[0]  = gnt_id;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 2'd2;
      vld_q  <= '0;
      id_q   <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
    end
  end

  assign tail_v  = vld_q[MEM_LAT-1];
  assign tail_id = id_q[MEM_LAT-1];

  always_comb begin
    rvalid = 3'b000;
    if (tail_v) begin
      unique case (tail_id)
        2'd1:    rvalid = 3'b010;
        2'd2:    rvalid = 3'b100;
        default: rvalid = 3'b001;
      endcase
    end
  end

  assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule
